// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcodes, FSM encoding and flag-vector layout.
// Used by the sequential ALU and by the decoder/control unit.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;
    localparam int unsigned ALU_OPW   = 2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

    // Bit positions inside the registered flag vector
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_W     = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operand and result channel between register-read, the ALU and write-back.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OPW   = ALU_OPW
);

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf
    );

    // The ALU itself
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first partial product is folded into the start cycle so done_o pulses WIDTH-1 cycles later.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [PW-1:0]    src_mcand;
    logic [PW-1:0]    src_acc;
    logic [WIDTH-1:0] src_mplier;
    logic             busy;

    // cnt_q counts completed iterations; non-zero means an operation is in flight
    assign busy = (cnt_q != '0);

    always_comb begin
        src_mcand  = start_i ? {WIDTH'(0), a_i} : mcand_q;
        src_mplier = start_i ? b_i : mplier_q;
        src_acc    = start_i ? PW'(0) : acc_q;

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        if (start_i || busy) begin
            acc_d    = src_acc + (src_mplier[0] ? src_mcand : PW'(0));
            mcand_d  = src_mcand << 1;
            mplier_d = src_mplier >> 1;
        end

        if (start_i) begin
            cnt_d = CNT_W'(1);
        end else if (busy) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ADD/NAND/SUB, iterative MUL, registered result and flags.
// Owns the valid/ready protocol, the IDLE/MUL_BUSY FSM and all flag generation.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OPW   = ALU_OPW
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus_io
);

    localparam int unsigned PW = 2 * WIDTH;

    alu_state_e        state_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  result_q;
    logic [FLAG_W-1:0] flags_q;

    logic              in_ready_c;
    logic              accept_c;
    logic              drain_c;
    logic              is_mul_c;

    logic [WIDTH:0]    sum_c;
    logic [WIDTH:0]    diff_c;
    logic [WIDTH-1:0]  alu_res_c;
    logic              alu_carry_c;
    logic              alu_ovf_c;
    logic [FLAG_W-1:0] alu_flags_c;
    logic [FLAG_W-1:0] mul_flags_c;

    logic              mul_done;
    logic [PW-1:0]     mul_prod;

    // Accept only when idle and the output slot is empty or being drained this cycle
    assign in_ready_c = (state_q == ST_IDLE) && (!out_valid_q || bus_io.out_ready);
    assign accept_c   = bus_io.in_valid && in_ready_c;
    assign drain_c    = out_valid_q && bus_io.out_ready;
    assign is_mul_c   = (bus_io.op == OPW'(OP_MUL));

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept_c && is_mul_c),
        .a_i       (bus_io.a),
        .b_i       (bus_io.b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Single-cycle datapath; carry of the extended subtraction is the unsigned borrow
    always_comb begin
        sum_c       = {1'b0, bus_io.a} + {1'b0, bus_io.b};
        diff_c      = {1'b0, bus_io.a} - {1'b0, bus_io.b};
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;

        case (bus_io.op)
            OPW'(OP_ADD): begin
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (bus_io.a[WIDTH-1] == bus_io.b[WIDTH-1]) &&
                              (sum_c[WIDTH-1] != bus_io.a[WIDTH-1]);
            end
            OPW'(OP_SUB): begin
                alu_res_c   = diff_c[WIDTH-1:0];
                alu_carry_c = diff_c[WIDTH];
                alu_ovf_c   = (bus_io.a[WIDTH-1] != bus_io.b[WIDTH-1]) &&
                              (diff_c[WIDTH-1] != bus_io.a[WIDTH-1]);
            end
            OPW'(OP_NAND): begin
                alu_res_c = ~(bus_io.a & bus_io.b);
            end
            default: begin
            end
        endcase

        alu_flags_c             = '0;
        alu_flags_c[FLAG_ZERO]  = ~|alu_res_c;
        alu_flags_c[FLAG_CARRY] = alu_carry_c;
        alu_flags_c[FLAG_OVF]   = alu_ovf_c;

        mul_flags_c             = '0;
        mul_flags_c[FLAG_ZERO]  = ~|mul_prod[WIDTH-1:0];
        mul_flags_c[FLAG_OVF]   = |mul_prod[PW-1:WIDTH];
    end

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            if (drain_c) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (is_mul_c) begin
                            state_q <= ST_MUL_BUSY;
                        end else begin
                            result_q    <= alu_res_c;
                            flags_q     <= alu_flags_c;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    // Slot was freed at accept, so completion can always load it
                    if (mul_done) begin
                        result_q    <= mul_prod[WIDTH-1:0];
                        flags_q     <= mul_flags_c;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready_c;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.result    = result_q;
    assign bus_io.zero      = flags_q[FLAG_ZERO];
    assign bus_io.carry     = flags_q[FLAG_CARRY];
    assign bus_io.ovf       = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16: op results, flags, latency, backpressure,
// streaming and asynchronous reset during a multiply.
module tb_alu_seq;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    alu_seq_if #(.WIDTH(16), .OPW(2)) bus ();

    alu_seq #(
        .WIDTH (16),
        .OPW   (2)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Cycles from accept to out_valid, and how many of those cycles had in_ready low
    task automatic wait_valid(output int lat, output int lowc);
        lat  = 1;
        lowc = 0;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.in_ready) lowc++;
            step();
            lat++;
        end
    endtask

    // Packs {out_valid, zero, carry, ovf, result}
    task automatic chk_out(input string tag, input logic [15:0] res,
                           input logic z, input logic c, input logic o);
        chk(tag, {12'h0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.result},
                 {12'h0, 1'b1, z, c, o, res});
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic z, input logic c,
                          input logic o, input int exp_lat);
        int lat;
        int lowc;
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        send(op, a, b);
        wait_valid(lat, lowc);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(lowc), 32'(exp_lat - 1));
        chk_out(tag, res, z, c, o);
        step();
        chk({tag, " drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [15:0] sa   [8] = '{16'h0001, 16'h0010, 16'h7FFF, 16'h8000,
                              16'hFFFE, 16'h1234, 16'h00FF, 16'hAAAA};
    logic [15:0] sb   [8] = '{16'h0001, 16'h0020, 16'h0001, 16'h8000,
                              16'h0001, 16'h4321, 16'h0001, 16'h5555};
    logic [15:0] sres [8] = '{16'h0002, 16'h0030, 16'h8000, 16'h0000,
                              16'hFFFF, 16'h5555, 16'h0100, 16'hFFFF};
    logic        sc   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        so   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int stable;
        int pulses;
        int lat;
        int lowc;

        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("reset outputs", {15'h0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.result},
                             32'h0);
        rst = 1'b0;
        step();
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Single-cycle ops and multiplies
        run_op("add_ffff_0001",  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        run_op("sub_0003_0005",  2'b10, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1);
        run_op("sub_8000_0001",  2'b10, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1);
        run_op("nand_ffff_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        run_op("nand_f0f0_ff00", 2'b01, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1);
        run_op("mul_0012_0034",  2'b11, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 17);
        run_op("mul_0100_0100",  2'b11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 17);
        run_op("mul_ffff_ffff",  2'b11, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17);

        // Backpressure: result held, new op refused, then drain and accept together
        bus.out_ready = 1'b0;
        send(2'b00, 16'h1234, 16'h1111);
        wait_valid(lat, lowc);
        chk("bp latency", 32'(lat), 32'd1);
        chk_out("bp add", 16'h2345, 1'b0, 1'b0, 1'b0);
        bus.op       = 2'b10;
        bus.a        = 16'h0010;
        bus.b        = 16'h0001;
        bus.in_valid = 1'b1;
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid && bus.result == 16'h2345 && !bus.in_ready && !bus.zero)
                stable++;
            step();
        end
        chk("bp stable_cycles", 32'(stable), 32'd5);
        bus.out_ready = 1'b1;
        #1;
        chk("bp in_ready_on_drain", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk_out("bp sub", 16'h000F, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp drained", 32'(bus.out_valid), 32'd0);

        // Streaming: one ADD accepted and one result produced every cycle
        for (int i = 0; i < 8; i++) begin
            bus.op       = 2'b00;
            bus.a        = sa[i];
            bus.b        = sb[i];
            bus.in_valid = 1'b1;
            chk($sformatf("stream%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            step();
            chk($sformatf("stream%0d out", i),
                {13'h0, bus.out_valid, bus.carry, bus.ovf, bus.result},
                {13'h0, 1'b1, sc[i], so[i], sres[i]});
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a multiply
        send(2'b11, 16'h0012, 16'h0034);
        repeat (6) step();
        chk("mid_mul busy", 32'(bus.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset outputs",
            {15'h0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.result}, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk("post_reset in_ready", 32'(bus.in_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.out_valid) pulses++;
            step();
        end
        chk("aborted_mul no_output", 32'(pulses), 32'd0);

        // Recovery after reset
        run_op("post_reset mul", 2'b11, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 17);
        run_op("post_reset add", 2'b00, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
